arbiter_puf_nbit: RTL



---
 rtl/arbiter_puf_nbit_pkg.sv | 33 +++
 rtl/arbiter_puf_nbit_if.sv | 28 ++
 rtl/arbiter_puf_nbit_chain.sv | 40 ++++
 rtl/arbiter_puf_nbit.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/arbiter_puf_nbit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arbiter_puf_pkg
// Purpose  : Shared FSM state encoding and challenge-derivation helper for
//            the multi-bit arbiter PUF.
// Revision : 1.0 - initial release
// ============================================================================
package arbiter_puf_pkg;

    localparam int MAX_CHAL_W = 64;

    typedef logic [2:0] puf_state_t;

    localparam puf_state_t ST_IDLE   = 3'd0;
    localparam puf_state_t ST_ARM    = 3'd1;
    localparam puf_state_t ST_FIRE   = 3'd2;
    localparam puf_state_t ST_SAMPLE = 3'd3;
    localparam puf_state_t ST_RELAX  = 3'd4;
    localparam puf_state_t ST_DONE   = 3'd5;

    // Rotate the low w bits of v left by n (n < w); bits at and above w are zero.
    function automatic logic [MAX_CHAL_W-1:0] rotl_chal(
        input logic [MAX_CHAL_W-1:0] v,
        input int unsigned           w,
        input int unsigned           n
    );
        logic [MAX_CHAL_W-1:0] m;
        m = ~({MAX_CHAL_W{1'b1}} << w);
        return ((v << n) | (v >> (w - n))) & m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arbiter_puf_nbit_if.sv
`default_nettype none
// ============================================================================
// Module   : arbiter_puf_nbit_if
// Purpose  : Request/response bundle between the key controller and the PUF.
// Revision : 1.0 - initial release
// ============================================================================
interface arbiter_puf_nbit_if #(
    parameter int CHAL_W = 8,
    parameter int RESP_W = 8
);
    logic              start;
    logic [CHAL_W-1:0] challenge;
    logic              busy;
    logic              resp_valid;
    logic [RESP_W-1:0] response;
    logic [RESP_W-1:0] unstable;

    modport master (
        output start, challenge,
        input  busy, resp_valid, response, unstable
    );

    modport slave (
        input  start, challenge,
        output busy, resp_valid, response, unstable
    );
endinterface
`default_nettype wire

// File: rtl/arbiter_puf_nbit_chain.sv
`default_nettype none
// ============================================================================
// Module   : puf_arbiter_chain
// Purpose  : Two racing mux paths steered by sel; the arbiter flop records
//            which path wins. Must be preserved untouched through synthesis.
// Revision : 1.0 - initial release
// ============================================================================
module puf_arbiter_chain #(
    parameter int CHAL_W = 8
) (
    input  logic              pulse,
    input  logic [CHAL_W-1:0] sel,
    output logic              arb_raw
);

    for (genvar i = 0; i < CHAL_W; i++) begin : g_stage
        (* keep = "true", dont_touch = "true" *) logic w_top_in;
        (* keep = "true", dont_touch = "true" *) logic w_bot_in;
        (* keep = "true", dont_touch = "true" *) logic w_top_out;
        (* keep = "true", dont_touch = "true" *) logic w_bot_out;

        if (i == 0) begin : g_first
            assign w_top_in = pulse;
            assign w_bot_in = pulse;
        end else begin : g_next
            assign w_top_in = g_stage[i-1].w_top_out;
            assign w_bot_in = g_stage[i-1].w_bot_out;
        end

        // sel=1 swaps the two paths through this stage
        assign w_top_out = sel[i] ? w_bot_in : w_top_in;
        assign w_bot_out = sel[i] ? w_top_in : w_bot_in;
    end

    always_ff @(posedge g_stage[CHAL_W-1].w_bot_out) begin
        arb_raw <= g_stage[CHAL_W-1].w_top_out;
    end

endmodule
`default_nettype wire

// File: rtl/arbiter_puf_nbit.sv
`default_nettype none
// ============================================================================
// Module   : arbiter_puf_nbit
// Purpose  : Multi-bit arbiter PUF: one chain evaluated VOTE_N times per
//            response bit with a rotated challenge, majority-voted.
// Revision : 1.0 - initial release
// ============================================================================
module arbiter_puf_nbit
    import arbiter_puf_pkg::*;
#(
    parameter int CHAL_W     = 8,
    parameter int RESP_W     = 8,
    parameter int VOTE_N     = 5,
    parameter int SETTLE_CYC = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    arbiter_puf_nbit_if.slave    bus
);

    localparam int c_OW = $clog2(VOTE_N + 1);
    localparam int c_VW = (VOTE_N > 1) ? $clog2(VOTE_N) : 1;
    localparam int c_BW = (RESP_W > 1) ? $clog2(RESP_W) : 1;
    localparam int c_SW = $clog2(SETTLE_CYC + 1);

    localparam logic [c_OW-1:0] c_HALF   = c_OW'(VOTE_N / 2);
    localparam logic [c_OW-1:0] c_VOTES  = c_OW'(VOTE_N);
    localparam logic [c_VW-1:0] c_VLAST  = c_VW'(VOTE_N - 1);
    localparam logic [c_BW-1:0] c_BLAST  = c_BW'(RESP_W - 1);
    localparam logic [c_SW-1:0] c_SETTLE = c_SW'(SETTLE_CYC);

    puf_state_t        r_state;
    logic [CHAL_W-1:0] r_chal;
    logic [CHAL_W-1:0] r_sel;
    logic              r_pulse;
    logic [1:0]        r_sync;
    logic [c_OW-1:0]   r_ones;
    logic [c_VW-1:0]   r_vote;
    logic [c_BW-1:0]   r_bit;
    logic [c_SW-1:0]   r_cnt;
    logic [RESP_W-1:0] r_resp_sh;
    logic [RESP_W-1:0] r_unst_sh;
    logic [RESP_W-1:0] r_response;
    logic [RESP_W-1:0] r_unstable;
    logic              r_busy;
    logic              r_valid;

    logic              w_arb_raw;
    logic              w_arb_q;
    int unsigned       w_rot_n;
    logic [CHAL_W-1:0] w_chal_i;

    assign w_rot_n  = 32'(r_bit) % CHAL_W;
    assign w_chal_i = CHAL_W'(rotl_chal(MAX_CHAL_W'(r_chal), CHAL_W, w_rot_n));
    assign w_arb_q  = r_sync[1];

    (* keep = "true", dont_touch = "true" *)
    puf_arbiter_chain #(
        .CHAL_W (CHAL_W)
    ) u_chain (
        .pulse   (r_pulse),
        .sel     (r_sel),
        .arb_raw (w_arb_raw)
    );

    // The arbiter flop is clocked by the chain, so its output is asynchronous here
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], w_arb_raw};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_chal     <= '0;
            r_sel      <= '0;
            r_pulse    <= 1'b0;
            r_ones     <= '0;
            r_vote     <= '0;
            r_bit      <= '0;
            r_cnt      <= '0;
            r_resp_sh  <= '0;
            r_unst_sh  <= '0;
            r_response <= '0;
            r_unstable <= '0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_chal  <= bus.challenge;
                        r_bit   <= '0;
                        r_vote  <= '0;
                        r_ones  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    r_sel   <= w_chal_i;
                    r_pulse <= 1'b1;
                    r_cnt   <= c_SETTLE;
                    r_state <= ST_FIRE;
                end
                ST_FIRE: begin
                    if (r_cnt == c_SW'(1)) begin
                        r_pulse <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= ST_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt - c_SW'(1);
                    end
                end
                ST_SAMPLE: begin
                    r_ones  <= r_ones + c_OW'(w_arb_q);
                    r_pulse <= 1'b0;
                    r_cnt   <= c_SETTLE;
                    r_state <= ST_RELAX;
                end
                ST_RELAX: begin
                    if (r_cnt != c_SW'(1)) begin
                        r_cnt <= r_cnt - c_SW'(1);
                    end else if (r_vote != c_VLAST) begin
                        r_cnt   <= '0;
                        r_vote  <= r_vote + c_VW'(1);
                        r_state <= ST_ARM;
                    end else begin
                        // Results go to shadow registers; outputs change only in DONE
                        r_resp_sh[r_bit] <= (r_ones > c_HALF);
                        r_unst_sh[r_bit] <= (r_ones != '0) && (r_ones != c_VOTES);
                        r_cnt  <= '0;
                        r_ones <= '0;
                        r_vote <= '0;
                        if (r_bit != c_BLAST) begin
                            r_bit   <= r_bit + c_BW'(1);
                            r_state <= ST_ARM;
                        end else begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_response <= r_resp_sh;
                    r_unstable <= r_unst_sh;
                    r_valid    <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_pulse <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.resp_valid = r_valid;
    assign bus.response   = r_response;
    assign bus.unstable   = r_unstable;

endmodule
`default_nettype wire
